send_capture_param_verifla: RTL and testbench

SEND_CAPTURE_PARAM_VERIFLA -- requirements
Module: send_capture_param_verifla

---
 rtl/send_capture_param_verifla.sv | 157 +++++++++++++++
 tb/tb_send_capture_param_verifla.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/send_capture_param_verifla.sv
// Dumps the capture memory over a byte-wide UART, newest sample first, optionally
// preceded by a header octet. All state moves only on baud_clk_posedge-qualified edges.
module send_capture_param_verifla #(
  parameter int unsigned ADDR_BITS    = 4,
  parameter int unsigned MEM_DEPTH    = 16,
  parameter int unsigned WORD_OCTETS  = 2,
  parameter bit          MSB_FIRST    = 1'b0,
  parameter bit          SEND_HEADER  = 1'b1,
  parameter logic [7:0]  HEADER_OCTET = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       baud_clk_posedge,
  input  logic                       sc_run,
  input  logic                       sc_abort,
  input  logic [ADDR_BITS-1:0]       sc_start_addr,
  output logic                       ack_sc_run,
  output logic                       sc_done,
  output logic                       sc_aborted,
  output logic [ADDR_BITS-1:0]       mem_port_B_address,
  input  logic [8*WORD_OCTETS-1:0]   mem_port_B_dout,
  output logic                       xmitH,
  output logic [7:0]                 xmit_dataH,
  input  logic                       xmit_doneH
);

  localparam int unsigned W    = 8 * WORD_OCTETS;
  localparam int unsigned CntW = ADDR_BITS + 1;
  localparam int unsigned OctW = $clog2(WORD_OCTETS + 1);

  localparam logic [ADDR_BITS-1:0] AddrLast = ADDR_BITS'(MEM_DEPTH - 1);
  localparam logic [CntW-1:0]      WordLast = CntW'(MEM_DEPTH - 1);
  localparam logic [OctW-1:0]      OctCount = OctW'(WORD_OCTETS);

  typedef enum logic [2:0] {
    StIdle, StAck, StHdrSend, StSetAddr, StGetData, StSendOctet, StWaitSent, StWordSent
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [CntW-1:0]       word_cnt_q, word_cnt_d;
  logic [OctW-1:0]       octet_cnt_q, octet_cnt_d;
  logic [W-1:0]          shift_q, shift_d;
  logic                  hdr_q, hdr_d;
  logic                  abort_now;

  assign abort_now = sc_abort && (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      word_cnt_q  <= '0;
      octet_cnt_q <= '0;
      shift_q     <= '0;
      hdr_q       <= 1'b0;
    end else if (baud_clk_posedge) begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_cnt_q  <= word_cnt_d;
      octet_cnt_q <= octet_cnt_d;
      shift_q     <= shift_d;
      hdr_q       <= hdr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_cnt_d  = word_cnt_q;
    octet_cnt_d = octet_cnt_q;
    shift_d     = shift_q;
    hdr_d       = hdr_q;
    if (abort_now) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (sc_run && !sc_abort) begin
            // Start addresses beyond the populated depth clamp to the last word.
            addr_d     = ({1'b0, sc_start_addr} > WordLast) ? AddrLast : sc_start_addr;
            word_cnt_d = '0;
            hdr_d      = 1'b0;
            state_d    = StAck;
          end
        end
        StAck:     state_d = SEND_HEADER ? StHdrSend : StSetAddr;
        StHdrSend: begin
          hdr_d   = 1'b1;
          state_d = StWaitSent;
        end
        StSetAddr: state_d = StGetData;
        StGetData: begin
          shift_d     = mem_port_B_dout;
          octet_cnt_d = '0;
          state_d     = StSendOctet;
        end
        StSendOctet: begin
          shift_d     = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
          octet_cnt_d = octet_cnt_q + 1'b1;
          state_d     = StWaitSent;
        end
        StWaitSent: begin
          if (xmit_doneH) begin
            if (hdr_q) begin
              hdr_d   = 1'b0;
              state_d = StSetAddr;
            end else if (octet_cnt_q < OctCount) begin
              state_d = StSendOctet;
            end else begin
              state_d = StWordSent;
            end
          end
        end
        StWordSent: begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q < WordLast) begin
            addr_d  = (addr_q == '0) ? AddrLast : addr_q - 1'b1;
            state_d = StSetAddr;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    ack_sc_run         = 1'b0;
    sc_done            = 1'b0;
    sc_aborted         = 1'b0;
    mem_port_B_address = '0;
    xmitH              = 1'b0;
    xmit_dataH         = 8'h00;
    if (abort_now) begin
      sc_done    = 1'b1;
      sc_aborted = 1'b1;
    end else begin
      case (state_q)
        StAck:     ack_sc_run = 1'b1;
        StHdrSend: begin
          xmitH      = 1'b1;
          xmit_dataH = HEADER_OCTET;
        end
        StSetAddr: mem_port_B_address = addr_q;
        StSendOctet: begin
          xmitH      = 1'b1;
          xmit_dataH = MSB_FIRST ? shift_q[W-1 -: 8] : shift_q[7:0];
        end
        StWordSent: sc_done = (word_cnt_q == WordLast);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_send_capture_param_verifla.sv
// Drives two instances (LSB-first with header, MSB-first without) from shared stimulus and
// checks every transmitted octet against a queue built from the dump rules.
module tb_send_capture_param_verifla;

  logic        clk;
  logic        rst_l;
  logic        baud;
  logic        sc_run;
  logic        sc_abort;
  logic [3:0]  start_addr;
  logic        ack   [2];
  logic        scd   [2];
  logic        abd   [2];
  logic [3:0]  maddr [2];
  logic [15:0] mdout [2];
  logic        xmit  [2];
  logic [7:0]  xdata [2];
  logic        xdone [2];

  logic [15:0] mem [16];
  logic [7:0]  exp0[$], exp1[$], rx0[$], rx1[$];
  logic [7:0]  lit35 [17];

  int total, bad;
  int div, cyc, hold;
  int gap [2];
  int done_cnt [2], abrt_cnt [2], ack_cnt [2], xclk [2];
  logic prev_x [2];

  send_capture_param_verifla #(
    .ADDR_BITS(4), .MEM_DEPTH(8), .WORD_OCTETS(2),
    .MSB_FIRST(1'b0), .SEND_HEADER(1'b1), .HEADER_OCTET(8'hA5)
  ) dut0 (
    .clk(clk), .rst_l(rst_l), .baud_clk_posedge(baud), .sc_run(sc_run),
    .sc_abort(sc_abort), .sc_start_addr(start_addr), .ack_sc_run(ack[0]),
    .sc_done(scd[0]), .sc_aborted(abd[0]), .mem_port_B_address(maddr[0]),
    .mem_port_B_dout(mdout[0]), .xmitH(xmit[0]), .xmit_dataH(xdata[0]),
    .xmit_doneH(xdone[0])
  );

  send_capture_param_verifla #(
    .ADDR_BITS(4), .MEM_DEPTH(8), .WORD_OCTETS(2),
    .MSB_FIRST(1'b1), .SEND_HEADER(1'b0), .HEADER_OCTET(8'hA5)
  ) dut1 (
    .clk(clk), .rst_l(rst_l), .baud_clk_posedge(baud), .sc_run(sc_run),
    .sc_abort(sc_abort), .sc_start_addr(start_addr), .ack_sc_run(ack[1]),
    .sc_done(scd[1]), .sc_aborted(abd[1]), .mem_port_B_address(maddr[1]),
    .mem_port_B_dout(mdout[1]), .xmitH(xmit[1]), .xmit_dataH(xdata[1]),
    .xmit_doneH(xdone[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous capture memory, clocked on enabled edges only.
  always @(posedge clk) begin
    if (baud) begin
      mdout[0] <= mem[maddr[0]];
      mdout[1] <= mem[maddr[1]];
    end
  end

  function automatic void check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endfunction

  // Reference: header, then MEM_DEPTH words walking down from the clamped start.
  function automatic void build_expect(input int start);
    int a;
    int ad;
    a = (start >= 8) ? 7 : start;
    exp0.delete();
    exp1.delete();
    exp0.push_back(8'hA5);
    for (int w = 0; w < 8; w++) begin
      ad = ((a - w) % 8 + 8) % 8;
      exp0.push_back(mem[ad][7:0]);
      exp0.push_back(mem[ad][15:8]);
      exp1.push_back(mem[ad][15:8]);
      exp1.push_back(mem[ad][7:0]);
    end
  endfunction

  function automatic void take_octet(input int i, input logic [7:0] got);
    logic [7:0] want;
    if (i == 0) begin
      rx0.push_back(got);
      if (exp0.size() == 0) begin
        check("extra_xmit0", 1, 0);
        return;
      end
      want = exp0.pop_front();
    end else begin
      rx1.push_back(got);
      if (exp1.size() == 0) begin
        check("extra_xmit1", 1, 0);
        return;
      end
      want = exp1.pop_front();
    end
    check($sformatf("octet%0d", i), got, want);
  endfunction

  // Baud enable and UART done responder; inputs change 1 time unit after posedge.
  initial begin
    baud = 1'b0;
    cyc = 0;
    xdone[0] = 1'b0;
    xdone[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      baud = ((cyc % div) == 0);
      for (int i = 0; i < 2; i++) begin
        if (baud && hold == 0 && gap[i] > 0) begin
          gap[i]--;
          xdone[i] = (gap[i] == 0);
        end else begin
          xdone[i] = 1'b0;
        end
      end
    end
  end

  // Compare process: observes each state once, in the clk cycle that ends on an enabled edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (xmit[i]) xclk[i]++;
      if (!rst_l) begin
        for (int i = 0; i < 2; i++)
          check("reset_outputs", {ack[i], scd[i], abd[i], xmit[i], xdata[i], maddr[i]}, 0);
      end else if (baud) begin
        for (int i = 0; i < 2; i++) begin
          if (xmit[i]) begin
            check("strobe_one_cycle", prev_x[i], 0);
            take_octet(i, xdata[i]);
            gap[i] = $urandom_range(1, 3);
          end else begin
            check("idle_data_zero", xdata[i], 0);
          end
          prev_x[i] = xmit[i];
          if (scd[i]) done_cnt[i]++;
          if (abd[i]) begin
            abrt_cnt[i]++;
            check("aborted_with_done", scd[i], 1);
          end
          if (ack[i]) ack_cnt[i]++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0;
      abrt_cnt[i] = 0;
      ack_cnt[i]  = 0;
      xclk[i]     = 0;
      prev_x[i]   = 1'b0;
    end
    rx0.delete();
    rx1.delete();
  endtask

  // Holds the given inputs high across exactly one enabled edge.
  task automatic pulse_inputs(input logic run, input logic abort);
    sc_run   = run;
    sc_abort = abort;
    do @(posedge clk); while (!baud);
    #1;
    sc_run   = 1'b0;
    sc_abort = 1'b0;
  endtask

  task automatic start_dump(input int start);
    start_addr = start[3:0];
    build_expect(start);
    clear_counts();
    pulse_inputs(1'b1, 1'b0);
  endtask

  task automatic wait_dump(input int aborted);
    int cnt;
    cnt = 0;
    while ((done_cnt[0] == 0 || done_cnt[1] == 0) && cnt < 6000) begin
      step(1);
      cnt++;
    end
    step(8);
    check("dump_timeout", cnt < 6000, 1);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("done_count%0d", i), done_cnt[i], 1);
      check($sformatf("abort_count%0d", i), abrt_cnt[i], aborted);
      check($sformatf("ack_count%0d", i), ack_cnt[i], 1);
    end
    if (aborted == 0) begin
      check("remaining0", exp0.size(), 0);
      check("remaining1", exp1.size(), 0);
    end
  endtask

  initial begin
    int cnt;
    total = 0;
    bad = 0;
    div = 1;
    hold = 0;
    gap[0] = 0;
    gap[1] = 0;
    rst_l = 1'b0;
    sc_run = 1'b0;
    sc_abort = 1'b0;
    start_addr = '0;
    clear_counts();
    lit35 = '{8'hA5, 8'h03, 8'h12, 8'h02, 8'h12, 8'h01, 8'h12, 8'h00, 8'h12,
              8'h07, 8'h12, 8'h06, 8'h12, 8'h05, 8'h12, 8'h04, 8'h12};
    step(4);
    rst_l = 1'b1;
    step(4);

    // Directed dump with a recognisable memory image.
    for (int a = 0; a < 16; a++) mem[a] = 16'h1200 + 16'(a);
    start_dump(3);
    wait_dump(0);
    check("lit_len0", rx0.size(), 17);
    for (int k = 0; k < 17; k++) check($sformatf("lit_hdr_lsb[%0d]", k), rx0[k], lit35[k]);
    check("lit_len1", rx1.size(), 16);
    check("lit_msb[0]", rx1[0], 8'h12);
    check("lit_msb[1]", rx1[1], 8'h03);
    check("lit_msb[2]", rx1[2], 8'h12);
    check("lit_msb[3]", rx1[3], 8'h02);

    // Out-of-range start clamps to the last word and ends at address 0.
    start_dump(9);
    wait_dump(0);
    check("clamp_first0", rx0[1], 8'h07);
    check("clamp_last0", rx0[15], 8'h00);
    check("clamp_first1", rx1[1], 8'h07);
    check("clamp_last1", rx1[15], 8'h00);

    // Abort during the third WAIT_SENT of the header instance.
    start_dump(3);
    cnt = 0;
    while (rx0.size() < 3 && cnt < 2000) begin
      step(1);
      cnt++;
    end
    check("abort_wait_timeout", cnt < 2000, 1);
    pulse_inputs(1'b0, 1'b1);
    step(20);
    exp0.delete();
    exp1.delete();
    step(30);
    check("abort_octets0", rx0.size(), 3);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort_done%0d", i), done_cnt[i], 1);
      check($sformatf("abort_flag%0d", i), abrt_cnt[i], 1);
    end
    start_dump(3);
    wait_dump(0);

    // run together with abort in IDLE is ignored.
    clear_counts();
    pulse_inputs(1'b1, 1'b1);
    step(20);
    check("run_abort_ack0", ack_cnt[0], 0);
    check("run_abort_ack1", ack_cnt[1], 0);
    check("run_abort_rx", rx0.size() + rx1.size(), 0);

    // Reset mid-word while the UART withholds completion.
    for (int a = 0; a < 16; a++) mem[a] = 16'($urandom);
    start_dump($urandom_range(0, 15));
    cnt = 0;
    while (rx0.size() < 5 && cnt < 2000) begin
      step(1);
      cnt++;
    end
    hold = 1;
    step(4);
    rst_l = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      check("async_reset_outputs", {ack[i], scd[i], abd[i], xmit[i], xdata[i], maddr[i]}, 0);
    step(3);
    rst_l = 1'b1;
    exp0.delete();
    exp1.delete();
    gap[0] = 0;
    gap[1] = 0;
    hold = 0;
    clear_counts();
    step(40);
    check("post_reset_done", done_cnt[0] + done_cnt[1], 0);
    check("post_reset_ack", ack_cnt[0] + ack_cnt[1], 0);

    // Randomized dumps, alternating full-rate and one-in-four enables.
    for (int n = 0; n < 6; n++) begin
      div = (n % 2 == 1) ? 4 : 1;
      for (int a = 0; a < 16; a++) mem[a] = 16'($urandom);
      start_dump($urandom_range(0, 15));
      if (n == 2) begin
        step(40);
        pulse_inputs(1'b1, 1'b0);
      end
      wait_dump(0);
      if (div == 4) begin
        check("slow_xmit_clks0", xclk[0], 17 * 4);
        check("slow_xmit_clks1", xclk[1], 16 * 4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
